// File: rtl/alu_req_arbiter_if.sv
// Bundle between two ALU requesters, the shared ALU and the response consumer.
// slave = arbiter side, master = client/environment side.
interface alu_req_arbiter_if #(
    parameter int W = 4
);
    logic         req0_valid, req0_ready;
    logic [2:0]   req0_op;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [2:0]   req1_op;
    logic [W-1:0] req1_a, req1_b;
    logic [2:0]   alu_ch;
    logic [W-1:0] alu_a, alu_b, alu_f;
    logic         alu_zero, alu_over, alu_cout;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_f;
    logic         rsp_zero, rsp_over, rsp_cout, rsp_err;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_f, alu_zero, alu_over, alu_cout, rsp_ready,
        output req0_ready, req1_ready, alu_ch, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_f, rsp_zero, rsp_over, rsp_cout, rsp_err
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_f, alu_zero, alu_over, alu_cout, rsp_ready,
        input  req0_ready, req1_ready, alu_ch, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_f, rsp_zero, rsp_over, rsp_cout, rsp_err
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Two-requester arbiter in front of one combinational ALU: grant, one EXEC cycle,
// then a held, tagged response. Op 3'b010 is rejected without touching the ALU.
module alu_req_arbiter #(
    parameter int W     = 4,
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_req_arbiter_if.slave  bus
);
    localparam logic [2:0] OP_ILLEGAL = 3'b010;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state_q, state_d;
    logic         rr_q, rr_d;
    logic [2:0]   ch_q, ch_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic         id_q, id_d;
    logic         rid_q, rid_d;
    logic [W-1:0] f_q, f_d;
    logic         zero_q, zero_d, over_q, over_d, cout_q, cout_d, err_q, err_d;

    logic [1:0]          vld, gnt;
    logic [1:0][2:0]     op;
    logic [1:0][W-1:0]   opa, opb;
    logic                win;

    assign vld = {bus.req1_valid, bus.req0_valid};
    assign op  = {bus.req1_op, bus.req0_op};
    assign opa = {bus.req1_a, bus.req0_a};
    assign opb = {bus.req1_b, bus.req0_b};

    // Ties go to the rr pointer side, or always to req0 in fixed-priority mode.
    always_comb begin
        win = 1'b0;
        if (vld == 2'b11) win = RR_EN ? rr_q : 1'b0;
        else              win = vld[1];
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        ch_d    = ch_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        rid_d   = rid_q;
        f_d     = f_q;
        zero_d  = zero_q;
        over_d  = over_q;
        cout_d  = cout_q;
        err_d   = err_q;
        gnt     = 2'b00;
        case (state_q)
            IDLE: begin
                if (|vld) begin
                    gnt[win] = 1'b1;
                    id_d     = win;
                    if (RR_EN) rr_d = ~win;
                    if (op[win] == OP_ILLEGAL) begin
                        state_d = RESP;
                        rid_d   = win;
                        f_d     = '0;
                        zero_d  = 1'b0;
                        over_d  = 1'b0;
                        cout_d  = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        // ALU regs load only for legal ops so they stay quiet otherwise.
                        state_d = EXEC;
                        ch_d    = op[win];
                        a_d     = opa[win];
                        b_d     = opb[win];
                    end
                end
            end
            EXEC: begin
                f_d     = bus.alu_f;
                zero_d  = bus.alu_zero;
                over_d  = bus.alu_over;
                cout_d  = bus.alu_cout;
                err_d   = 1'b0;
                rid_d   = id_q;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            ch_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            rid_q   <= 1'b0;
            f_q     <= '0;
            zero_q  <= 1'b0;
            over_q  <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            ch_q    <= ch_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            rid_q   <= rid_d;
            f_q     <= f_d;
            zero_q  <= zero_d;
            over_q  <= over_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.alu_ch     = ch_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = rid_q;
    assign bus.rsp_f      = f_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_over   = over_q;
    assign bus.rsp_cout   = cout_q;
    assign bus.rsp_err    = err_q;
endmodule
